// File: rtl/sram_access_ctrl.sv
// -----------------------------------------------------------------------------
// sram_access_ctrl
//
// Purpose:
//   Sequences one SRAM row access per accepted request through four phases:
//     IDLE -> PRE (bitline precharge) -> ACC (wordline active) -> REC -> IDLE.
//   A write drives the bitline write drivers for the whole ACC phase. A read
//   fires the sense amplifiers in the last ACC cycle and captures sense_data
//   on the edge that leaves ACC. Requests are not queued: req_valid is only
//   looked at while the block sits in IDLE.
//
// Parameters:
//   ADDR_WIDTH        row address width
//   DATA_WIDTH        write/read data width
//   PRECHARGE_CYCLES  PRE phase length in cycles (1..15)
//   WL_CYCLES         ACC phase length in cycles (1..15)
//
// Ports:
//   clk           in   single clock, rising edge
//   rst           in   synchronous active-high reset
//   req_valid     in   access request pending
//   req_ready     out  request accepted this cycle (registered, == IDLE)
//   req_we        in   1 = write, 0 = read
//   req_addr      in   row address
//   req_wdata     in   write data
//   dec_addr      out  row decoder address (latched request address)
//   dec_enable    out  row decoder enable, gates the wordline
//   precharge_en  out  bitline precharge enable
//   write_en      out  bitline write driver enable
//   bl_wdata      out  data for the write drivers
//   sense_en      out  sense amplifier fire
//   sense_data    in   sense amplifier outputs
//   rdata         out  last read result
//   rdata_valid   out  one-cycle pulse when rdata updates
//   busy          out  high in every state except IDLE
//
// All control outputs come straight from flops updated together with the
// state register, so each output is a registered decode of the next state.
// -----------------------------------------------------------------------------
module sram_access_ctrl #(
  parameter int ADDR_WIDTH       = 6,
  parameter int DATA_WIDTH       = 8,
  parameter int PRECHARGE_CYCLES = 1,
  parameter int WL_CYCLES        = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic [ADDR_WIDTH-1:0] dec_addr,
  output logic                  dec_enable,
  output logic                  precharge_en,
  output logic                  write_en,
  output logic [DATA_WIDTH-1:0] bl_wdata,
  output logic                  sense_en,
  input  logic [DATA_WIDTH-1:0] sense_data,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_valid,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_ACC  = 2'd2,
    ST_REC  = 2'd3
  } state_t;

  // Phase counters hold "cycles remaining after this one", so a phase of N
  // cycles loads N-1 on entry and exits when the counter reads zero.
  localparam logic [3:0] PRE_LOAD = 4'(PRECHARGE_CYCLES - 1);
  localparam logic [3:0] WL_LOAD  = 4'(WL_CYCLES - 1);

  // A one-cycle ACC phase must fire sense_en on its very first cycle.
  localparam logic WL_SINGLE = (WL_CYCLES == 1);

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_dec_addr;
  logic [DATA_WIDTH-1:0] r_bl_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_req_ready;
  logic                  r_dec_enable;
  logic                  r_precharge_en;
  logic                  r_write_en;
  logic                  r_sense_en;
  logic                  r_rdata_valid;
  logic                  r_busy;

  logic                  w_accept;
  logic                  w_cnt_done;
  logic [3:0]            w_cnt_dec;

  // r_req_ready is only high in IDLE, so this is the IDLE handshake.
  assign w_accept   = r_req_ready & req_valid;
  assign w_cnt_done = (r_cnt == 4'd0);
  // Saturating decrement: the counter never wraps below zero.
  assign w_cnt_dec  = w_cnt_done ? r_cnt : (r_cnt - 4'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_cnt          <= 4'd0;
      r_we           <= 1'b0;
      r_dec_addr     <= '0;
      r_bl_wdata     <= '0;
      r_rdata        <= '0;
      r_req_ready    <= 1'b1;
      r_dec_enable   <= 1'b0;
      r_precharge_en <= 1'b0;
      r_write_en     <= 1'b0;
      r_sense_en     <= 1'b0;
      r_rdata_valid  <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      // rdata_valid is a single-cycle pulse; only the ACC exit raises it.
      r_rdata_valid <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state        <= ST_PRE;
            r_dec_addr     <= req_addr;
            r_we           <= req_we;
            r_bl_wdata     <= req_wdata;
            r_cnt          <= PRE_LOAD;
            r_precharge_en <= 1'b1;
            r_req_ready    <= 1'b0;
            r_busy         <= 1'b1;
          end
        end

        ST_PRE: begin
          if (w_cnt_done) begin
            // Precharge drops on the same edge the wordline rises, so the
            // two enables can never overlap.
            r_state        <= ST_ACC;
            r_cnt          <= WL_LOAD;
            r_precharge_en <= 1'b0;
            r_dec_enable   <= 1'b1;
            r_write_en     <= r_we;
            r_sense_en     <= ~r_we & WL_SINGLE;
          end else begin
            r_cnt <= w_cnt_dec;
          end
        end

        ST_ACC: begin
          if (w_cnt_done) begin
            r_state      <= ST_REC;
            r_cnt        <= 4'd0;
            r_dec_enable <= 1'b0;
            r_write_en   <= 1'b0;
            r_sense_en   <= 1'b0;
            if (!r_we) begin
              r_rdata       <= sense_data;
              r_rdata_valid <= 1'b1;
            end
          end else begin
            r_cnt <= w_cnt_dec;
            // Counter at 1 now means the next cycle is the last ACC cycle.
            r_sense_en <= ~r_we & (r_cnt == 4'd1);
          end
        end

        ST_REC: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
          r_busy      <= 1'b0;
        end

        default: begin
          r_state        <= ST_IDLE;
          r_cnt          <= 4'd0;
          r_req_ready    <= 1'b1;
          r_dec_enable   <= 1'b0;
          r_precharge_en <= 1'b0;
          r_write_en     <= 1'b0;
          r_sense_en     <= 1'b0;
          r_busy         <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready    = r_req_ready;
  assign dec_addr     = r_dec_addr;
  assign dec_enable   = r_dec_enable;
  assign precharge_en = r_precharge_en;
  assign write_en     = r_write_en;
  assign bl_wdata     = r_bl_wdata;
  assign sense_en     = r_sense_en;
  assign rdata        = r_rdata;
  assign rdata_valid  = r_rdata_valid;
  assign busy         = r_busy;

endmodule

// File: doc/sram_access_ctrl.md
SRAM_ACCESS_CTRL -- requirements
Module: sram_access_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 6, SHALL set the row address width driven to the row decoder.
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the write-data and read-data width.
REQ-003 Parameter PRECHARGE_CYCLES, default 1, range 1-15, SHALL set the precharge phase length in cycles.
REQ-004 Parameter WL_CYCLES, default 2, range 1-15, SHALL set the wordline-active phase length in cycles.
REQ-005 Port clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-006 Port rst  input  1  SHALL be the synchronous, active-high reset.
REQ-007 Port req_valid  input  1  SHALL flag a pending access request.
REQ-008 Port req_ready  output  1  SHALL flag that a request is accepted this cycle.
REQ-009 Port req_we  input  1  SHALL select a write (1) or a read (0).
REQ-010 Port req_addr  input  ADDR_WIDTH  SHALL carry the row address.
REQ-011 Port req_wdata  input  DATA_WIDTH  SHALL carry the write data.
REQ-012 Port dec_addr  output  ADDR_WIDTH  SHALL drive the row decoder address.
REQ-013 Port dec_enable  output  1  SHALL drive the row decoder enable, which gates the wordline.
REQ-014 Port precharge_en  output  1  SHALL enable the bitline precharge.
REQ-015 Port write_en  output  1  SHALL enable the bitline write drivers.
REQ-016 Port bl_wdata  output  DATA_WIDTH  SHALL carry the data for the write drivers.
REQ-017 Port sense_en  output  1  SHALL fire the sense amplifiers.
REQ-018 Port sense_data  input  DATA_WIDTH  SHALL carry the sense amplifier outputs.
REQ-019 Port rdata  output  DATA_WIDTH  SHALL hold the last read result.
REQ-020 Port rdata_valid  output  1  SHALL pulse high for one cycle when rdata updates.
REQ-021 Port busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-022 The FSM SHALL have exactly four states: IDLE, PRE, ACC and REC.
REQ-023 req_ready SHALL equal (state==IDLE) and SHALL NOT depend combinationally on req_valid.
REQ-024 On the edge where req_valid and req_ready are both high, the block SHALL latch req_addr, req_we and req_wdata and SHALL enter PRE.
REQ-025 req_valid SHALL be ignored while the block is outside IDLE; no request is queued.
REQ-026 In PRE, precharge_en SHALL be 1 for exactly PRECHARGE_CYCLES cycles, then the FSM SHALL enter ACC.
REQ-027 In ACC, dec_enable SHALL be 1 for exactly WL_CYCLES cycles, then the FSM SHALL enter REC.
REQ-028 During a write, write_en SHALL be 1 for all ACC cycles, with bl_wdata equal to the latched data.
REQ-029 During a read, sense_en SHALL be 1 only in the last ACC cycle.
REQ-030 During a read, sense_data SHALL be captured into rdata on the edge that leaves ACC.
REQ-031 REC SHALL last 1 cycle with precharge_en, dec_enable, write_en and sense_en all 0, then the FSM SHALL return to IDLE.
REQ-032 rdata_valid SHALL be 1 in the REC cycle of a read only; it SHALL never assert for a write.
REQ-033 dec_addr SHALL hold the latched address, stable from PRE through REC, and SHALL keep it in IDLE.
REQ-034 precharge_en and dec_enable SHALL never be high in the same cycle.
REQ-035 write_en and sense_en SHALL never be high in the same cycle.
REQ-036 All control outputs SHALL be registered.
REQ-037 The access period SHALL be PRECHARGE_CYCLES+WL_CYCLES+2 cycles from accept to the next req_ready (5 with defaults).
REQ-038 rdata SHALL hold its value across writes and idle periods until the next read completes.
REQ-039 Phase counters SHALL be 4 bits, SHALL load at each phase entry and SHALL count down without wrap.

Reset
REQ-040 With rst high at an edge, the FSM SHALL go to IDLE.
REQ-041 On that reset edge, dec_addr, bl_wdata, rdata and the counters SHALL be set to 0.
REQ-042 On that reset edge, dec_enable, precharge_en, write_en, sense_en, rdata_valid and busy SHALL be set to 0, and req_ready SHALL be set to 1.
REQ-043 A reset in any state SHALL abort the access; no rdata_valid or write_en SHALL follow, and a request that is valid during reset SHALL NOT be accepted.

Verification
REQ-044 Read, defaults: accept addr 0x2A at edge 0, sense_data=0x5C -> precharge_en cycle 1, dec_enable cycles 2-3, sense_en cycle 3, rdata=0x5C with rdata_valid cycle 4, req_ready cycle 5.
REQ-045 Write addr 0x3F, data 0xA5 -> write_en=1 and bl_wdata=0xA5 in both ACC cycles, dec_addr=0x3F, rdata_valid never 1, rdata unchanged.
REQ-046 Back-to-back: req_valid held high for 3 requests -> accepts exactly 5 cycles apart, with no overlap of precharge_en and dec_enable.
REQ-047 Reset asserted during the second ACC cycle of a read -> next cycle in IDLE, all enables 0, rdata=0, no rdata_valid.
REQ-048 PRECHARGE_CYCLES=3, WL_CYCLES=1 -> precharge_en 3 cycles, dec_enable and sense_en together 1 cycle, period 6.
REQ-049 req_valid toggled while busy -> ignored; only the request present in IDLE is served.
